dmem_access_ctrl: RTL

- Sequences data-memory load/store transactions for the 3-stage pipeline core.
- Consumes the decoded control flags (is_mem_op, is_load_op, is_store_op, is_byte_op) plus the effective address and store data.
- Drives a valid/yumi request channel and a response channel to data memory, and stalls the pipeline until each transaction completes.
- Formats byte/word data in both directions and returns load results to the register-file writeback path.

---
 rtl/dmem_access_ctrl_pkg.sv | 23 ++
 rtl/dmem_lane_fmt.sv | 32 +++
 rtl/dmem_access_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_ctrl_state_e;

  localparam int unsigned kBYTE_LANES = 4;
  localparam int unsigned kDATA_W     = kBYTE_LANES * 8;
  localparam int unsigned kADDR_W     = 32;

  // Request fields are sized to the widest supported address; the top narrows on output.
  typedef struct packed {
    logic [kADDR_W-1:0]     addr;
    logic                   we;
    logic [kBYTE_LANES-1:0] mask;
    logic [kDATA_W-1:0]     wdata;
  } mem_req_s;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store replicate/mask and load lane-select with zero-extend.
module dmem_lane_fmt
  import dmem_access_ctrl_pkg::*;
(
  input  logic                   st_is_byte,
  input  logic [1:0]             st_lane,
  input  logic [kDATA_W-1:0]     st_wdata,
  output logic [kBYTE_LANES-1:0] st_mask,
  output logic [kDATA_W-1:0]     st_data,
  input  logic                   ld_is_byte,
  input  logic [1:0]             ld_lane,
  input  logic [kDATA_W-1:0]     ld_rdata,
  output logic [kDATA_W-1:0]     ld_data
);

  always_comb begin
    st_mask = '1;
    st_data = st_wdata;
    if (st_is_byte) begin
      st_mask = kBYTE_LANES'(1) << st_lane;
      st_data = {kBYTE_LANES{st_wdata[7:0]}};
    end
  end

  always_comb begin
    ld_data = ld_rdata;
    if (ld_is_byte) begin
      ld_data = kDATA_W'(ld_rdata[{ld_lane, 3'b000} +: 8]);
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory load/store sequencer: valid/yumi request, response capture, pipeline stall.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start_i,
  input  logic                 is_load_i,
  input  logic                 is_store_i,
  input  logic                 is_byte_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [RF_ADDR_W-1:0] rd_i,
  output logic                 mem_v_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_mask_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic                 mem_yumi_i,
  input  logic                 mem_resp_v_i,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 stall_o,
  output logic                 wb_v_o,
  output logic [RF_ADDR_W-1:0] wb_rd_o,
  output logic [DATA_W-1:0]    wb_data_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_ctrl_state_e        state_q, state_d;
  mem_req_s               req_q;
  logic                   is_load_q, is_byte_q, err_q, err_d;
  logic [1:0]             lane_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [RF_ADDR_W-1:0]   rd_q;
  logic [DATA_W-1:0]      ld_data_q;
  logic                   accept, misalign, timeout_hit, capture;
  logic [kBYTE_LANES-1:0] st_mask;
  logic [kDATA_W-1:0]     st_data, ld_data;

  dmem_lane_fmt u_fmt (
    .st_is_byte (is_byte_i),
    .st_lane    (addr_i[1:0]),
    .st_wdata   (kDATA_W'(wdata_i)),
    .st_mask    (st_mask),
    .st_data    (st_data),
    .ld_is_byte (is_byte_q),
    .ld_lane    (lane_q),
    .ld_rdata   (kDATA_W'(mem_rdata_i)),
    .ld_data    (ld_data)
  );

  assign misalign    = !is_byte_i && (addr_i[1:0] != 2'b00);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          accept  = 1'b1;
          err_d   = misalign;
          state_d = misalign ? DONE : REQ;
        end
      end
      // A completing handshake in the final budgeted cycle wins over the timeout.
      REQ: begin
        if (mem_yumi_i) begin
          state_d = req_q.we ? DONE : WAIT;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      WAIT: begin
        if (mem_resp_v_i) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      is_load_q <= 1'b0;
      is_byte_q <= 1'b0;
      lane_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= '0;
      ld_data_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        req_q.addr  <= kADDR_W'({addr_i[ADDR_W-1:2], 2'b00});
        req_q.we    <= is_store_i;
        req_q.mask  <= st_mask;
        req_q.wdata <= st_data;
        // Store takes precedence if decode ever raises both flags.
        is_load_q   <= !is_store_i;
        is_byte_q   <= is_byte_i;
        lane_q      <= addr_i[1:0];
        rd_q        <= rd_i;
        cnt_q       <= '0;
      end else if (state_q == REQ || state_q == WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        ld_data_q <= DATA_W'(ld_data);
      end
    end
  end

  assign mem_v_o     = (state_q == REQ);
  assign mem_addr_o  = req_q.addr[ADDR_W-1:0];
  assign mem_we_o    = req_q.we;
  assign mem_mask_o  = req_q.mask;
  assign mem_wdata_o = DATA_W'(req_q.wdata);
  assign stall_o     = (state_q == REQ) || (state_q == WAIT) || accept;
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == DONE) && err_q;
  assign wb_v_o      = (state_q == DONE) && !err_q && is_load_q;
  assign wb_rd_o     = rd_q;
  assign wb_data_o   = ld_data_q;

endmodule
